// File: rtl/sequential_signed_div8x4_if.sv
// -----------------------------------------------------------------------------
// sequential_signed_div8x4_if
// Start/operand/result bundle for the sequential signed divider.
//   St        start request (driven by master)
//   Dividend  2N-bit signed dividend (driven by master)
//   Divisor   N-bit signed divisor (driven by master)
//   Quot      N-bit signed quotient (driven by slave)
//   Rem       N-bit signed remainder (driven by slave)
//   V         overflow / divide-by-zero flag (driven by slave)
//   busy      operation in flight (driven by slave)
//   done      result valid, held until the next start (driven by slave)
// -----------------------------------------------------------------------------
interface sequential_signed_div8x4_if #(
  parameter int N = 4
);
  logic                  St;
  logic signed [2*N-1:0] Dividend;
  logic signed [N-1:0]   Divisor;
  logic signed [N-1:0]   Quot;
  logic signed [N-1:0]   Rem;
  logic                  V;
  logic                  busy;
  logic                  done;

  modport master (
    output St, Dividend, Divisor,
    input  Quot, Rem, V, busy, done
  );

  modport slave (
    input  St, Dividend, Divisor,
    output Quot, Rem, V, busy, done
  );
endinterface

// File: rtl/sequential_signed_div8x4.sv
// -----------------------------------------------------------------------------
// sequential_signed_div8x4
// Sequential signed divider: 2N-bit signed dividend / N-bit signed divisor.
// Works on magnitudes with a restoring shift/subtract loop producing one
// quotient bit per clock; signs are applied in the final cycle. Results follow
// truncating division (quotient toward zero, remainder takes dividend sign).
// A quotient that does not fit in +/-(2^(N-1)-1), or a zero divisor, is
// reported through V with Quot=Rem=0.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   slave side of sequential_signed_div8x4_if (St, Dividend, Divisor in;
//         Quot, Rem, V, busy, done out -- all outputs registered)
// Timing: St sampled in IDLE at edge 0; done rises at edge N+2, or at edge 1
// on overflow / divide-by-zero.
// -----------------------------------------------------------------------------
module sequential_signed_div8x4 #(
  parameter int N = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  sequential_signed_div8x4_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DIV   = 2'd2;
  localparam logic [1:0] S_FIX   = 2'd3;

  // Magnitude of a 2N-bit two's-complement value; the most negative value
  // maps onto 2^(2N-1), which still fits in 2N unsigned bits.
  function automatic logic [2*N-1:0] mag_dividend(input logic signed [2*N-1:0] x);
    mag_dividend = x[2*N-1] ? -x : x;
  endfunction

  function automatic logic [N-1:0] mag_divisor(input logic signed [N-1:0] x);
    mag_divisor = x[N-1] ? -x : x;
  endfunction

  // Reattach a sign to an unsigned magnitude.
  function automatic logic signed [N-1:0] apply_sign(input logic neg,
                                                     input logic [N-1:0] m);
    apply_sign = neg ? -m : m;
  endfunction

  // Control and registered outputs
  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_v;
  logic signed [N-1:0] r_quot;
  logic signed [N-1:0] r_rem;

  // Working datapath
  logic                r_sign_q;
  logic                r_sign_r;
  logic [2*N-1:0]      r_a;
  logic [N-1:0]        r_b;
  logic [N-1:0]        r_r;
  logic [N-1:0]        r_l;

  logic [2*N-1:0]      w_b_lim;
  logic                w_ovf;
  logic [N:0]          w_r_sh;
  logic                w_ge;
  logic [N-1:0]        w_r_sub;

  // Overflow when |quotient| >= 2^(N-1), i.e. A >= B * 2^(N-1).
  assign w_b_lim = {{N{1'b0}}, r_b} << (N - 1);
  assign w_ovf   = (r_b == '0) || (r_a >= w_b_lim);

  // One restoring step. The partial remainder held in r_r is always < B, so
  // it fits in N bits; only the shifted value needs the extra top bit.
  assign w_r_sh  = {r_r, r_l[N-1]};
  assign w_ge    = (w_r_sh >= {1'b0, r_b});
  assign w_r_sub = w_r_sh[N-1:0] - r_b;

  // Control FSM: IDLE -> CHECK -> DIV (N cycles) -> FIX -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_v     <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.St) begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_ovf) begin
            r_v     <= 1'b1;
            r_quot  <= '0;
            r_rem   <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_v     <= 1'b0;
            r_cnt   <= CW'(N);
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        default: begin
          r_quot  <= apply_sign(r_sign_q, r_l);
          r_rem   <= apply_sign(r_sign_r, r_r);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: operand capture, initial split, shift/subtract
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (bus.St) begin
          r_sign_q <= bus.Dividend[2*N-1] ^ bus.Divisor[N-1];
          r_sign_r <= bus.Dividend[2*N-1];
          r_a      <= mag_dividend(bus.Dividend);
          r_b      <= mag_divisor(bus.Divisor);
        end
      end
      S_CHECK: begin
        r_r <= r_a[2*N-1:N];
        r_l <= r_a[N-1:0];
      end
      S_DIV: begin
        r_r <= w_ge ? w_r_sub : w_r_sh[N-1:0];
        r_l <= {r_l[N-2:0], w_ge};
      end
      default: begin
      end
    endcase
  end

  assign bus.Quot = r_quot;
  assign bus.Rem  = r_rem;
  assign bus.V    = r_v;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_sequential_signed_div8x4.sv
// -----------------------------------------------------------------------------
// tb_sequential_signed_div8x4
// Drives an N=4 and an N=6 divider from one clock. Expected results come from
// a Verilog / and % model and are queued when an operation is launched, then
// popped and compared when done rises.
// -----------------------------------------------------------------------------
module tb_sequential_signed_div8x4;

  logic clk;
  logic rst;

  sequential_signed_div8x4_if #(.N(4)) b4 ();
  sequential_signed_div8x4_if #(.N(6)) b6 ();

  sequential_signed_div8x4 #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  sequential_signed_div8x4 #(.N(6)) u_dut6 (.clk(clk), .rst(rst), .bus(b6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    q;
    int    r;
    int    v;
    int    lat;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Truncating-division reference; V when divisor is zero or |q| > 2^(n-1)-1.
  task automatic model(input int n, input int dvd, input int dvs,
                       output int q, output int r, output int v);
    int lim;
    lim = (1 << (n - 1)) - 1;
    q = 0; r = 0; v = 0;
    if (dvs == 0) begin
      v = 1;
    end else begin
      q = dvd / dvs;
      r = dvd % dvs;
      if (q > lim || q < -lim) v = 1;
    end
    if (v != 0) begin
      q = 0; r = 0;
    end
  endtask

  task automatic drive(input int n, input int st, input int dvd, input int dvs);
    if (n == 4) begin
      b4.St = st[0]; b4.Dividend = dvd[7:0];  b4.Divisor = dvs[3:0];
    end else begin
      b6.St = st[0]; b6.Dividend = dvd[11:0]; b6.Divisor = dvs[5:0];
    end
  endtask

  function automatic int get_q(input int n);
    if (n == 4) return int'(b4.Quot);
    return int'(b6.Quot);
  endfunction
  function automatic int get_r(input int n);
    if (n == 4) return int'(b4.Rem);
    return int'(b6.Rem);
  endfunction
  function automatic int get_v(input int n);
    if (n == 4) return int'(b4.V);
    return int'(b6.V);
  endfunction
  function automatic int get_busy(input int n);
    if (n == 4) return int'(b4.busy);
    return int'(b6.busy);
  endfunction
  function automatic int get_done(input int n);
    if (n == 4) return int'(b4.done);
    return int'(b6.done);
  endfunction

  // Launch one operation; St stays high through edge 'hold' (edge 0 is the
  // accept edge) and the operand inputs are scrambled right after edge 0.
  task automatic run_op(input int n, input int dvd, input int dvs,
                        input int hold, input string tag);
    exp_t e;
    int q, r, v, cyc;
    model(n, dvd, dvs, q, r, v);
    e.tag = tag; e.q = q; e.r = r; e.v = v;
    e.lat = (v != 0) ? 1 : n + 2;
    sbq.push_back(e);

    @(negedge clk);
    drive(n, 1, dvd, dvs);
    @(posedge clk); #1;
    drive(n, (hold > 0) ? 1 : 0, ~dvd, dvs + 1);
    cyc = 0;
    while (get_done(n) == 0 && cyc < 3 * n) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc >= hold) drive(n, 0, ~dvd, dvs + 1);
    end
    drive(n, 0, 0, 0);

    e = sbq.pop_front();
    chk({e.tag, ":lat"},  cyc,          e.lat);
    chk({e.tag, ":done"}, get_done(n),  1);
    chk({e.tag, ":busy"}, get_busy(n),  0);
    chk({e.tag, ":V"},    get_v(n),     e.v);
    chk({e.tag, ":Quot"}, get_q(n),     e.q);
    chk({e.tag, ":Rem"},  get_r(n),     e.r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dvd, dvs, span;
    rst = 1'b1;
    drive(4, 0, 0, 0);
    drive(6, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset4:Quot", get_q(4), 0);
    chk("reset4:Rem",  get_r(4), 0);
    chk("reset4:V",    get_v(4), 0);
    chk("reset4:busy", get_busy(4), 0);
    chk("reset4:done", get_done(4), 0);
    chk("reset6:done", get_done(6), 0);
    @(negedge clk);
    rst = 1'b0;

    // Sign combinations; the first also holds St through edge 3 (ignored)
    run_op(4,   45,  7, 3, "45/7");
    run_op(4,  -45,  7, 0, "-45/7");
    run_op(4,   45, -7, 0, "45/-7");
    run_op(4,  -45, -7, 0, "-45/-7");

    // Range edges
    run_op(4,   55,  7, 0, "55/7");
    run_op(4,   56,  7, 0, "56/7");
    run_op(4, -128, -1, 0, "-128/-1");
    run_op(4,    0,  5, 0, "0/5");

    // Divide by zero, St still high at edge 1 while in CHECK
    run_op(4,   17,  0, 1, "17/0");
    repeat (3) @(posedge clk);
    #1;
    chk("17/0:done_held", get_done(4), 1);
    chk("17/0:busy_idle", get_busy(4), 0);
    chk("17/0:V_held",    get_v(4),    1);

    // Reset mid-operation: rst sampled at edge 3 of a 45/7 op
    @(negedge clk);
    drive(4, 1, 45, 7);
    @(posedge clk); #1;
    drive(4, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid:Quot", get_q(4), 0);
    chk("rstmid:Rem",  get_r(4), 0);
    chk("rstmid:V",    get_v(4), 0);
    chk("rstmid:busy", get_busy(4), 0);
    chk("rstmid:done", get_done(4), 0);
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid:no_result", get_done(4), 0);
    run_op(4,   50,  7, 0, "50/7");

    // N=6 directed
    run_op(6,  -45,  7, 0, "n6:-45/7");
    run_op(6,  503, 16, 0, "n6:503/16");
    run_op(6,  512, 16, 0, "n6:512/16");

    // Random: half full range, half with dividends near the legal window
    for (int i = 0; i < 2000; i++) begin
      int n;
      n = (i < 1000) ? 4 : 6;
      dvs  = int'($urandom_range(0, (1 << n) - 1)) - (1 << (n - 1));
      span = (i % 2 == 0) ? (1 << (2 * n - 1)) : (1 << (n + 1));
      dvd  = int'($urandom_range(0, 2 * span - 1)) - span;
      run_op(n, dvd, dvs, 0, $sformatf("rnd%0d:%0d/%0d", n, dvd, dvs));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
